wb_write_queue: RTL

- Write-back side of the 8x8-bit, two-write-port register file in the pipelined processor.
- Accepts register results from two execution lanes (lane A = ALU, lane B = memory/multi-cycle) over valid/ready handshakes and buffers them in order in a small queue.
- Retires up to two entries per cycle onto the register file write ports (we3/wa3/wd3, we4/wa4/wd4) and never drives the same address on both ports in one cycle.
- Exports a per-register busy scoreboard so decode can stall on pending writes.

---
 rtl/wb_write_queue.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wb_write_queue.sv
// Write-back queue for the dual-write-port register file: buffers lane A/B results
// in order and retires up to two per cycle, merging same-address pairs.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int AW    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [AW-1:0]        a_addr,
    input  logic [DW-1:0]        a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [AW-1:0]        b_addr,
    input  logic [DW-1:0]        b_data,
    input  logic                 hold,
    output logic                 we3,
    output logic [AW-1:0]        wa3,
    output logic [DW-1:0]        wd3,
    output logic                 we4,
    output logic [AW-1:0]        wa4,
    output logic [DW-1:0]        wd4,
    output logic [(1<<AW)-1:0]   busy,
    output logic [AW:0]          count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NR = 1 << AW;
    localparam int OW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    logic [AW-1:0] addr_mem_r [DEPTH];
    logic [DW-1:0] data_mem_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    logic [PW-1:0] next_s;
    logic [PW-1:0] tail_b_s;
    logic          push_a_s;
    logic          push_b_s;
    logic [1:0]    pop_s;
    logic [CW-1:0] count_next_s;

    function automatic logic [NR-1:0] onehot(input logic [AW-1:0] a);
        return {{(NR-1){1'b0}}, 1'b1} << a;
    endfunction

    // Lane handshakes from registered occupancy only; B yields a single free slot to A.
    always_comb begin
        a_ready      = (count_r < DEPTH_C);
        b_ready      = (count_r <= (DEPTH_C - TWO_C)) | ((count_r < DEPTH_C) & ~a_valid);
        push_a_s     = a_valid & a_ready;
        push_b_s     = b_valid & b_ready;
        tail_b_s     = tail_r + PW'(push_a_s);
        count_next_s = count_r + CW'(push_a_s) + CW'(push_b_s) - CW'(pop_s);
    end

    // Retirement selection from queue state; a same-address pair keeps only the younger value.
    always_comb begin
        we3    = 1'b0;
        wa3    = {AW{1'b0}};
        wd3    = {DW{1'b0}};
        we4    = 1'b0;
        wa4    = {AW{1'b0}};
        wd4    = {DW{1'b0}};
        pop_s  = 2'd0;
        next_s = head_r + PW'(1);
        if (!hold && (count_r != {CW{1'b0}})) begin
            if (count_r == ONE_C) begin
                we3   = 1'b1;
                wa3   = addr_mem_r[head_r];
                wd3   = data_mem_r[head_r];
                pop_s = 2'd1;
            end else if (addr_mem_r[head_r] == addr_mem_r[next_s]) begin
                we3   = 1'b1;
                wa3   = addr_mem_r[next_s];
                wd3   = data_mem_r[next_s];
                pop_s = 2'd2;
            end else begin
                we3   = 1'b1;
                wa3   = addr_mem_r[head_r];
                wd3   = data_mem_r[head_r];
                we4   = 1'b1;
                wa4   = addr_mem_r[next_s];
                wd4   = data_mem_r[next_s];
                pop_s = 2'd2;
            end
        end else begin
            pop_s = 2'd0;
        end
    end

    // Pending-write scoreboard over the occupied window starting at head.
    always_comb begin
        busy = {NR{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_r) begin
                busy = busy | onehot(addr_mem_r[head_r + PW'(i)]);
            end else begin
                busy = busy;
            end
        end
        count = OW'(count_r);
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= {AW{1'b0}};
                data_mem_r[i] <= {DW{1'b0}};
            end
        end else begin
            if (push_a_s) begin
                addr_mem_r[tail_r] <= a_addr;
                data_mem_r[tail_r] <= a_data;
            end
            if (push_b_s) begin
                addr_mem_r[tail_b_s] <= b_addr;
                data_mem_r[tail_b_s] <= b_data;
            end
            tail_r  <= tail_b_s + PW'(push_b_s);
            head_r  <= head_r + PW'(pop_s);
            count_r <= count_next_s;
        end
    end

endmodule
